multi_cycle_control_unit: RTL and testbench
===========================================

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 Parameter SINGLE_CYCLE_MEM, default 0: when 1, mem_ready is ignored and treated as 1.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low.
- opcode, in, 7: opcode field of the instruction register.
- alu_bcond, in, 1: branch condition from the ALU.
- halt_req, in, 1: ecall halt condition (x17==10), computed externally.
- mem_ready, in, 1: memory completes the current access this cycle.
- pc_write, out, 1: PC update enable.
- pc_source, out, 2: next-PC select: 0 PC+4 adder, 1 ALUOut, 2 ALU result.
- iord, out, 1: memory address select: 0 PC, 1 ALUOut.
- mem_read / mem_write, out, 1 each: memory access strobes.
- ir_write, out, 1: instruction register load.
- alu_src_a, out, 1: 0 PC, 1 rs1.
- alu_src_b, out, 2: 0 rs2, 1 constant 4, 2 immediate.
- alu_op, out, 2: 0 add, 1 compare/sub, 2 decode from funct fields.
- reg_write, mem_to_reg, pc_to_reg, out, 1 each: register-file writeback controls.
- is_ecall, out, 1: ecall is in decode.
- halted, out, 1: core has stopped.
- cycle_cnt, out, CNT_W: total cycles (only with PERF_CNT_EN).
- instr_cnt, out, CNT_W: retired instructions (only with PERF_CNT_EN).

Function
REQ-004 The FSM SHALL have the states IF, ID, EX, MEM, WB, HALT; all outputs SHALL be Moore-decoded from state and opcode; every output not listed for a state SHALL be 0.
REQ-005 Opcode values SHALL be:
- ARITHMETIC 0110011, ARITHMETIC_IMM 0010011, LOAD 0000011, STORE 0100011.
- BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
REQ-006 IF SHALL assert mem_read=1, iord=0, and ir_write=mem_ready; it SHALL hold while mem_ready=0 and go to ID on mem_ready=1.
REQ-007 ID SHALL drive alu_src_a=0, alu_src_b=2, alu_op=0 (PC+imm into ALUOut).
- ECALL: is_ecall=1; go to HALT if halt_req=1, else pc_write=1, pc_source=0, next state IF.
- Unrecognised opcode: retire as NOP (pc_write=1, pc_source=0), next state IF.
- All other opcodes: next state EX.
REQ-008 EX SHALL act per opcode:
- ARITHMETIC: a=1, b=0, alu_op=2; next WB.
- ARITHMETIC_IMM: a=1, b=2, alu_op=2; next WB.
- LOAD/STORE: a=1, b=2, alu_op=0; next MEM.
- JAL: a=0, b=2, alu_op=0; next WB.
- JALR: a=1, b=2, alu_op=0; next WB.
- BRANCH: a=1, b=0, alu_op=1, pc_write=1, pc_source=alu_bcond?1:0; next IF.
REQ-009 MEM SHALL assert iord=1 and mem_read (LOAD) or mem_write (STORE), and SHALL hold while mem_ready=0.
- LOAD with mem_ready=1: next WB.
- STORE with mem_ready=1: pc_write=1, pc_source=0, next IF.
REQ-010 WB SHALL assert reg_write=1 and pc_write=1, then go to IF.
- mem_to_reg=1 for LOAD.
- pc_to_reg=1 and pc_source=1 for JAL and JALR.
- pc_source=0 otherwise.
REQ-011 HALT SHALL be absorbing, with halted=1 and all strobes 0.
REQ-012 Exactly one pc_write pulse SHALL occur per retired instruction; retirement cycles are the pc_write cycles.

Reset
REQ-013 reset=0 SHALL force state IF asynchronously, including mid-access.
REQ-014 During reset, the outputs SHALL be the IF-state values with mem_ready=0 (mem_read=1, all others 0) and the counters SHALL be 0.

Configuration
REQ-015 Macro PERF_CNT_EN SHALL control the performance counters.
- Defined: cycle_cnt increments every non-HALT cycle; instr_cnt increments on each pc_write; both wrap modulo 2^CNT_W; both freeze in HALT.
- Undefined: both ports and their logic are absent.

Verification
REQ-016 ADD with SINGLE_CYCLE_MEM=1 -> IF,ID,EX,WB; reg_write=1 in WB only; 4 cycles; instr_cnt=1.
REQ-017 LW with mem_ready low 3 cycles in each of IF and MEM -> stalls hold all outputs; WB mem_to_reg=1; 11 cycles total.
REQ-018 BEQ with alu_bcond=1, then alu_bcond=0 -> EX pc_source=1, then EX pc_source=0; 3 cycles each; reg_write never 1.
REQ-019 ECALL with halt_req=1 -> HALT after ID, halted=1, counters frozen; with halt_req=0 -> back to IF, pc_source=0.
REQ-020 reset=0 asserted mid-MEM of a store -> mem_write=0 immediately, state IF; counters 0.
REQ-021 CNT_W=4 with 17 ADDs -> instr_cnt wraps to 1.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32 control FSM (IF/ID/EX/MEM/WB/HALT) driving datapath strobes.
// Optional performance counters are built when the PERF_CNT_EN macro is defined.
`default_nettype none

module multi_cycle_control_unit #(
  parameter int SINGLE_CYCLE_MEM = 0,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             alu_bcond,
  input  logic             halt_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_to_reg,
  output logic             is_ecall,
  output logic             halted
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   ready_w;

  assign ready_w = (SINGLE_CYCLE_MEM != 0) ? 1'b1 : mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_source  = 2'd0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    is_ecall   = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        // Gated by reset so the IR never loads while reset is held.
        ir_write = ready_w & reset;
        if (ready_w) state_d = S_ID;
      end

      S_ID: begin
        alu_src_b = 2'd2;
        case (opcode)
          OP_ECALL: begin
            is_ecall = 1'b1;
            if (halt_req) begin
              state_d = S_HALT;
            end else begin
              pc_write = 1'b1;
              state_d  = S_IF;
            end
          end
          OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
          default: begin
            pc_write = 1'b1;
            state_d  = S_IF;
          end
        endcase
      end

      S_EX: begin
        case (opcode)
          OP_ARITH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd2;
            state_d   = S_WB;
          end
          OP_ARITH_IMM: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = 2'd2;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_MEM;
          end
          OP_JAL: begin
            alu_src_b = 2'd2;
            state_d   = S_WB;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_WB;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd1;
            pc_write  = 1'b1;
            pc_source = alu_bcond ? 2'd1 : 2'd0;
            state_d   = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
        if (ready_w) begin
          if (opcode == OP_STORE) begin
            pc_write = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d  = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        if (opcode == OP_JAL || opcode == OP_JALR) begin
          pc_to_reg = 1'b1;
          pc_source = 2'd1;
        end
        state_d = S_IF;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_d = S_IF;
    endcase
  end

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cycle_q, instr_q;

  // pc_write is never raised in HALT, so freezing both counters there is enough.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (state_q != S_HALT) begin
      cycle_q <= cycle_q + CNT_ONE;
      if (pc_write) instr_q <= instr_q + CNT_ONE;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_control_unit.sv
// Randomized self-checking bench: instruction-level walk of the control sequence.
`default_nettype none

module tb_multi_cycle_control_unit;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ECL  = 7'b1110011;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       is_ecall;
    logic       halted;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst0_n, rst1_n;
  logic [6:0] opcode;
  logic       alu_bcond, halt_req, mem_ready;

  logic       a_pcw, a_iord, a_mr, a_mw, a_irw, a_sa, a_rw, a_m2r, a_p2r, a_ec, a_h;
  logic [1:0] a_pcs, a_sb, a_op;
  logic       b_pcw, b_iord, b_mr, b_mw, b_irw, b_sa, b_rw, b_m2r, b_p2r, b_ec, b_h;
  logic [1:0] b_pcs, b_sb, b_op;
`ifdef PERF_CNT_EN
  logic [3:0]  a_cyc, a_ins;
  logic [31:0] b_cyc, b_ins;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int ins   = 0;
  int sel   = 0;

  always #5 clk = ~clk;

  multi_cycle_control_unit #(.SINGLE_CYCLE_MEM(0), .CNT_W(4)) u_dut (
    .clk(clk), .reset(rst0_n), .opcode(opcode), .alu_bcond(alu_bcond),
    .halt_req(halt_req), .mem_ready(mem_ready),
    .pc_write(a_pcw), .pc_source(a_pcs), .iord(a_iord), .mem_read(a_mr),
    .mem_write(a_mw), .ir_write(a_irw), .alu_src_a(a_sa), .alu_src_b(a_sb),
    .alu_op(a_op), .reg_write(a_rw), .mem_to_reg(a_m2r), .pc_to_reg(a_p2r),
    .is_ecall(a_ec), .halted(a_h)
`ifdef PERF_CNT_EN
    , .cycle_cnt(a_cyc), .instr_cnt(a_ins)
`endif
  );

  // Second instance: zero-latency memory, its mem_ready tied low on purpose.
  multi_cycle_control_unit #(.SINGLE_CYCLE_MEM(1), .CNT_W(32)) u_dut_scm (
    .clk(clk), .reset(rst1_n), .opcode(opcode), .alu_bcond(alu_bcond),
    .halt_req(halt_req), .mem_ready(1'b0),
    .pc_write(b_pcw), .pc_source(b_pcs), .iord(b_iord), .mem_read(b_mr),
    .mem_write(b_mw), .ir_write(b_irw), .alu_src_a(b_sa), .alu_src_b(b_sb),
    .alu_op(b_op), .reg_write(b_rw), .mem_to_reg(b_m2r), .pc_to_reg(b_p2r),
    .is_ecall(b_ec), .halted(b_h)
`ifdef PERF_CNT_EN
    , .cycle_cnt(b_cyc), .instr_cnt(b_ins)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t obs();
    if (sel == 0)
      return {a_pcw, a_pcs, a_iord, a_mr, a_mw, a_irw, a_sa, a_sb, a_op,
              a_rw, a_m2r, a_p2r, a_ec, a_h};
    return {b_pcw, b_pcs, b_iord, b_mr, b_mw, b_irw, b_sa, b_sb, b_op,
            b_rw, b_m2r, b_p2r, b_ec, b_h};
  endfunction

  function automatic logic known(input logic [6:0] op);
    case (op)
      ADD, ADDI, LW, SW, BEQ, JAL, JALR, ECL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_cnt(input string tag);
`ifdef PERF_CNT_EN
    if (sel == 0) begin
      check({tag, "_cyc"}, {28'd0, a_cyc}, 32'(cyc % 16));
      check({tag, "_ins"}, {28'd0, a_ins}, 32'(ins % 16));
    end else begin
      check({tag, "_cyc"}, b_cyc, 32'(cyc));
      check({tag, "_ins"}, b_ins, 32'(ins));
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step(input string tag, input ctl_t e);
    #1;
    check(tag, 32'(obs()), 32'(e));
    check_cnt(tag);
    if (!e.halted) cyc++;
    if (e.pc_write) ins++;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    ctl_t e;
    if (sel == 0) rst0_n = 1'b0;
    else          rst1_n = 1'b0;
    mem_ready = 1'b1;
    cyc = 0;
    ins = 0;
    #1;
    e = '0;
    e.mem_read = 1'b1;
    check("RST", 32'(obs()), 32'(e));
    check_cnt("RST");
    @(negedge clk);
    @(negedge clk);
    if (sel == 0) rst0_n = 1'b1;
    else          rst1_n = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic bc, input logic hr,
                           input int sif, input int smem);
    ctl_t e;
    opcode    = op;
    alu_bcond = bc;
    halt_req  = hr;
    for (int i = 0; i < sif; i++) begin
      mem_ready = 1'b0;
      e = '0; e.mem_read = 1'b1;
      step("IF_STALL", e);
    end
    mem_ready = 1'b1;
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
    step("IF", e);

    mem_ready = 1'($urandom);
    e = '0; e.alu_src_b = 2'd2;
    if (op == ECL) begin
      e.is_ecall = 1'b1;
      if (hr) begin
        step("ID_ECALL", e);
        for (int i = 0; i < 3; i++) begin
          mem_ready = 1'($urandom);
          e = '0; e.halted = 1'b1;
          step("HALT", e);
        end
        return;
      end
      e.pc_write = 1'b1;
      step("ID_ECALL", e);
      return;
    end
    if (!known(op)) begin
      e.pc_write = 1'b1;
      step("ID_NOP", e);
      return;
    end
    step("ID", e);

    e = '0;
    case (op)
      ADD:     begin e.alu_src_a = 1'b1; e.alu_op = 2'd2; end
      ADDI:    begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 2'd2; end
      LW, SW:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
      JAL:     begin e.alu_src_b = 2'd2; end
      JALR:    begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
      default: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_write = 1'b1;
        e.pc_source = bc ? 2'd1 : 2'd0;
      end
    endcase
    step("EX", e);
    if (op == BEQ) return;

    if (op == LW || op == SW) begin
      e = '0; e.iord = 1'b1; e.mem_read = (op == LW); e.mem_write = (op == SW);
      for (int i = 0; i < smem; i++) begin
        mem_ready = 1'b0;
        step("MEM_STALL", e);
      end
      mem_ready = 1'b1;
      e.pc_write = (op == SW);
      step("MEM", e);
      if (op == SW) return;
    end

    mem_ready = 1'($urandom);
    e = '0; e.reg_write = 1'b1; e.pc_write = 1'b1; e.mem_to_reg = (op == LW);
    if (op == JAL || op == JALR) begin
      e.pc_to_reg = 1'b1;
      e.pc_source = 2'd1;
    end
    step("WB", e);
  endtask

  initial begin
    logic [6:0] ops [9];
    ctl_t       e;
    ops = '{ADD, ADDI, LW, SW, BEQ, JAL, JALR, ECL, BAD};
    rst0_n = 1'b0; rst1_n = 1'b0;
    opcode = ADD; alu_bcond = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
    sel = 0;
    @(negedge clk);
    reset_dut();

    run_instr(ADD, 1'b0, 1'b0, 0, 0);
    run_instr(LW, 1'b0, 1'b0, 3, 3);
    run_instr(BEQ, 1'b1, 1'b0, 0, 0);
    run_instr(BEQ, 1'b0, 1'b0, 0, 0);
    run_instr(ECL, 1'b0, 1'b0, 0, 0);
    run_instr(BAD, 1'b0, 1'b0, 1, 0);
    run_instr(JAL, 1'b0, 1'b0, 0, 0);
    run_instr(JALR, 1'b1, 1'b0, 0, 0);
    run_instr(SW, 1'b0, 1'b0, 0, 2);
    run_instr(ADDI, 1'b0, 1'b0, 2, 0);

    // Reset lands in the middle of a stalled store access.
    opcode = SW; halt_req = 1'b0; mem_ready = 1'b1;
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; step("IF", e);
    e = '0; e.alu_src_b = 2'd2; step("ID", e);
    e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; step("EX", e);
    mem_ready = 1'b0;
    e = '0; e.iord = 1'b1; e.mem_write = 1'b1; step("MEM_STALL", e);
    reset_dut();

    run_instr(ECL, 1'b0, 1'b1, 0, 0);
    reset_dut();

    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      logic       hr;
      op = ops[$urandom_range(0, 8)];
      hr = (op == ECL) && ($urandom_range(0, 3) == 0);
      run_instr(op, 1'($urandom), hr, $urandom_range(0, 3), $urandom_range(0, 3));
      if (hr) reset_dut();
    end

    reset_dut();
    for (int n = 0; n < 17; n++) run_instr(ADD, 1'b0, 1'b0, 0, 0);
`ifdef PERF_CNT_EN
    check("WRAP_INS", {28'd0, a_ins}, 32'd1);
`endif

    rst0_n = 1'b0;
    sel = 1;
    reset_dut();
    run_instr(ADD, 1'b0, 1'b0, 0, 0);
    run_instr(LW, 1'b0, 1'b0, 0, 0);
`ifdef PERF_CNT_EN
    check("SCM_INS", b_ins, 32'd2);
    check("SCM_CYC", b_cyc, 32'd9);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
